// File: rtl/riscv_instr_enc.sv
`default_nettype none
// ============================================================================
// Module   : riscv_instr_enc
// Purpose  : Two-stage valid/ready encoder that assembles a 32-bit RV32I
//            instruction word from opcode, funct, register and immediate
//            fields. The immediate in req_imm follows the core's decode
//            convention (B/J carry offset>>1, U carries bits [31:12]), so this
//            block is the exact inverse of the core's immediate decode.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            req_valid/req_ready   - request handshake
//            req_opcode..req_imm   - instruction fields (req_imm sign-extended)
//            rsp_valid/rsp_ready   - response handshake
//            rsp_instr, rsp_err    - encoded word and error flag
//            err_cnt               - saturating count of delivered errors
// Config   : RISCV_INSTR_ENC_RANGE_CHECK_EN - when defined, out-of-range
//            immediates also raise rsp_err (word still emitted, truncated).
// Revision : 1.0 - initial release
// ============================================================================
module riscv_instr_enc #(
  parameter int IBUS_DATA_WIDTH = 32,
  parameter int DBUS_DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [6:0]                 req_opcode,
  input  logic [2:0]                 req_funct3,
  input  logic [6:0]                 req_funct7,
  input  logic [4:0]                 req_rd,
  input  logic [4:0]                 req_rs1,
  input  logic [4:0]                 req_rs2,
  input  logic [DBUS_DATA_WIDTH-1:0] req_imm,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IBUS_DATA_WIDTH-1:0] rsp_instr,
  output logic                       rsp_err,
  output logic [15:0]                err_cnt
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd6
  } fmt_e;

  // --------------------------------------------------------------------------
  // Encoding of the incoming request (result is registered into E1)
  // --------------------------------------------------------------------------
  fmt_e                       fmt;
  logic                       is_shift;
  logic [IBUS_DATA_WIDTH-1:0] enc_instr;
  logic                       enc_err;

  // funct3 001 (SLLI) and 101 (SRLI/SRAI) share bits [1:0] = 01
  assign is_shift = (req_opcode == OPC_OP_IMM) && (req_funct3[1:0] == 2'b01);

  always_comb begin
    fmt = FMT_ILL;
    case (req_opcode)
      OPC_OP:                          fmt = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:  fmt = FMT_I;
      OPC_STORE:                       fmt = FMT_S;
      OPC_BRANCH:                      fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:              fmt = FMT_U;
      OPC_JAL:                         fmt = FMT_J;
      default:                         fmt = FMT_ILL;
    endcase
  end

  always_comb begin
    enc_instr = '0;
    case (fmt)
      FMT_R: enc_instr = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, req_opcode};
      FMT_I: begin
        if (is_shift) begin
          enc_instr = {req_funct7, req_imm[4:0], req_rs1, req_funct3, req_rd, req_opcode};
        end else begin
          enc_instr = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
        end
      end
      FMT_S: enc_instr = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], req_opcode};
      // req_imm holds offset[12:1]; bit 11 of it is offset bit 12
      FMT_B: enc_instr = {req_imm[11], req_imm[9:4], req_rs2, req_rs1, req_funct3,
                          req_imm[3:0], req_imm[10], req_opcode};
      FMT_U: enc_instr = {req_imm[19:0], req_rd, req_opcode};
      // req_imm holds offset[20:1]
      FMT_J: enc_instr = {req_imm[19], req_imm[9:0], req_imm[10], req_imm[18:11],
                          req_rd, req_opcode};
      default: enc_instr = '0;
    endcase
  end

`ifdef RISCV_INSTR_ENC_RANGE_CHECK_EN
  logic fits12;
  logic fits20;
  logic shamt_ok;
  logic range_err;

  // A value fits N signed bits when every bit from N-1 upward equals the sign
  assign fits12   = (&req_imm[DBUS_DATA_WIDTH-1:11]) || !(|req_imm[DBUS_DATA_WIDTH-1:11]);
  assign fits20   = (&req_imm[DBUS_DATA_WIDTH-1:19]) || !(|req_imm[DBUS_DATA_WIDTH-1:19]);
  assign shamt_ok = !(|req_imm[DBUS_DATA_WIDTH-1:5]);

  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_I:        range_err = is_shift ? !shamt_ok : !fits12;
      FMT_S, FMT_B: range_err = !fits12;
      FMT_U, FMT_J: range_err = !fits20;
      default:      range_err = 1'b0;
    endcase
  end

  assign enc_err = (fmt == FMT_ILL) || range_err;
`else
  // Upper immediate bits only matter for range checking
  logic unused_imm_hi;
  assign unused_imm_hi = ^req_imm[DBUS_DATA_WIDTH-1:20];

  assign enc_err = (fmt == FMT_ILL);
`endif

  // --------------------------------------------------------------------------
  // Pipeline control and next state
  // --------------------------------------------------------------------------
  logic                       e1_valid_q, e1_valid_d;
  logic [IBUS_DATA_WIDTH-1:0] e1_instr_q, e1_instr_d;
  logic                       e1_err_q,   e1_err_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [IBUS_DATA_WIDTH-1:0] rsp_instr_q, rsp_instr_d;
  logic                       rsp_err_q,   rsp_err_d;
  logic [15:0]                err_cnt_q,   err_cnt_d;

  logic e2_adv;
  logic e1_free;

  assign e2_adv  = !rsp_valid_q || rsp_ready;
  // E1 can take a new request when empty or when its content moves to E2
  assign e1_free = !e1_valid_q || e2_adv;
  assign req_ready = !rst && e1_free;

  always_comb begin
    e1_valid_d  = e1_valid_q;
    e1_instr_d  = e1_instr_q;
    e1_err_d    = e1_err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_instr_d = rsp_instr_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;

    if (e1_free) begin
      e1_valid_d = req_valid;
      if (req_valid) begin
        e1_instr_d = enc_instr;
        e1_err_d   = enc_err;
      end
    end

    if (e2_adv) begin
      rsp_valid_d = e1_valid_q;
      if (e1_valid_q) begin
        rsp_instr_d = e1_instr_q;
        rsp_err_d   = e1_err_q;
      end
    end

    if (rsp_valid_q && rsp_ready && rsp_err_q && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e1_valid_q  <= 1'b0;
      e1_instr_q  <= '0;
      e1_err_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      e1_valid_q  <= e1_valid_d;
      e1_instr_q  <= e1_instr_d;
      e1_err_q    <= e1_err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_instr_q <= rsp_instr_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_instr = rsp_instr_q;
  assign rsp_err   = rsp_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_instr_enc.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_instr_enc
// Purpose  : Self-checking bench for riscv_instr_enc. Directed test-plan
//            vectors plus randomized requests scored against a reference
//            model built from the RV32I field layout of byte offsets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_instr_enc;

  localparam int DW = 64;
`ifdef RISCV_INSTR_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [6:0]    req_opcode;
  logic [2:0]    req_funct3;
  logic [6:0]    req_funct7;
  logic [4:0]    req_rd;
  logic [4:0]    req_rs1;
  logic [4:0]    req_rs2;
  logic [DW-1:0] req_imm;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_instr;
  logic          rsp_err;
  logic [15:0]   err_cnt;

  always #5 clk = ~clk;

  riscv_instr_enc #(.IBUS_DATA_WIDTH(32), .DBUS_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_err(rsp_err), .err_cnt(err_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_rsp    = 0;
  int cyc      = 0;
  logic [15:0] model_cnt = 16'd0;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: builds the word from the architectural byte offset for
  // B/J and from plain masks/shifts for the other formats.
  function automatic exp_t ref_enc(input logic [6:0] opc, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [4:0] rd,
                                   input logic [4:0] rs1, input logic [4:0] rs2,
                                   input longint imm);
    logic [63:0] w, o, u, regs;
    logic oor, ill;
    exp_t r;
    w = 64'd0; oor = 1'b0; ill = 1'b0;
    u = 64'(imm);
    o = u << 1;  // byte offset for branch/jump
    regs = (64'(rs1) << 15) | (64'(f3) << 12);
    case (opc)
      7'h33: w = (64'(f7) << 25) | (64'(rs2) << 20) | regs | (64'(rd) << 7) | 64'(opc);
      7'h13, 7'h03, 7'h67: begin
        if (opc == 7'h13 && (f3 == 3'b001 || f3 == 3'b101)) begin
          w = (64'(f7) << 25) | ((u & 64'h1F) << 20) | regs | (64'(rd) << 7) | 64'(opc);
          oor = (imm < 0) || (imm > 31);
        end else begin
          w = ((u & 64'hFFF) << 20) | regs | (64'(rd) << 7) | 64'(opc);
          oor = (imm < -2048) || (imm > 2047);
        end
      end
      7'h23: begin
        w = (((u >> 5) & 64'h7F) << 25) | (64'(rs2) << 20) | regs | ((u & 64'h1F) << 7) | 64'(opc);
        oor = (imm < -2048) || (imm > 2047);
      end
      7'h63: begin
        w = (64'(o[12]) << 31) | (64'(o[10:5]) << 25) | (64'(rs2) << 20) | regs |
            (64'(o[4:1]) << 8) | (64'(o[11]) << 7) | 64'(opc);
        oor = (imm < -2048) || (imm > 2047);
      end
      7'h37, 7'h17: begin
        w = ((u & 64'hFFFFF) << 12) | (64'(rd) << 7) | 64'(opc);
        oor = (imm < -524288) || (imm > 524287);
      end
      7'h6F: begin
        w = (64'(o[20]) << 31) | (64'(o[10:1]) << 21) | (64'(o[11]) << 20) |
            (64'(o[19:12]) << 12) | (64'(rd) << 7) | 64'(opc);
        oor = (imm < -524288) || (imm > 524287);
      end
      default: begin
        w = 64'd0;
        ill = 1'b1;
      end
    endcase
    r.instr = w[31:0];
    r.err   = ill || (RC && oor);
    return r;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      model_cnt = 16'd0;
    end else begin
      chk("err_cnt", 64'(err_cnt), 64'(model_cnt));
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_instr", 64'(rsp_instr), 64'(e.instr));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          if (e.err && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        end
      end
      if (req_valid && req_ready)
        exp_q.push_back(ref_enc(req_opcode, req_funct3, req_funct7, req_rd,
                                req_rs1, req_rs2, longint'(req_imm)));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_req(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input longint imm);
    req_valid  = 1'b1;
    req_opcode = opc; req_funct3 = f3; req_funct7 = f7;
    req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
    req_imm = 64'(imm);
  endtask

  // Waits until the driven request is accepted; returns at posedge+1
  task automatic wait_accept(input bit rand_ready);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", 64'(n < 200), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 64'(n < 100), 64'd1);
    @(posedge clk); #1;
  endtask

  // Single request, then wait for its response and compare with constants
  task automatic expect_one(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input longint imm, input logic [31:0] want, input logic want_err);
    int n = 0;
    drive_req(opc, f3, 7'd0, rd, rs1, rs2, imm);
    wait_accept(1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_instr"}, 64'(rsp_instr), 64'(want));
    chk({tag, "_err"}, 64'(rsp_err), 64'(want_err));
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t ea;
    int c0;
    int r0;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_opcode = '0; req_funct3 = '0; req_funct7 = '0;
    req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_instr", 64'(rsp_instr), 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    chk("reset_err_cnt", 64'(err_cnt), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd1);

    // addi x1,x0,-1 with exact two-cycle latency
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drive_req(7'h13, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, -1);
    @(negedge clk);
    chk("addi_accept", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("addi_lat1_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    chk("addi_lat2_valid", 64'(rsp_valid), 64'd1);
    chk("addi_instr", 64'(rsp_instr), 64'hFFF00093);
    chk("addi_err", 64'(rsp_err), 64'd0);
    @(posedge clk); #1;

    expect_one("sw", 7'h23, 3'b010, 5'd0, 5'd3, 5'd2, 8, 32'h0021A423, 1'b0);
    expect_one("jal", 7'h6F, 3'b000, 5'd1, 5'd0, 5'd0, 1024, 32'h001000EF, 1'b0);
    expect_one("addi2048", 7'h13, 3'b000, 5'd1, 5'd0, 5'd0, 2048, 32'h80000093, RC);
    @(negedge clk);
    chk("addi2048_err_cnt", 64'(err_cnt), RC ? 64'd1 : 64'd0);
    @(posedge clk); #1;
    expect_one("illegal", 7'h7F, 3'b000, 5'd0, 5'd0, 5'd0, 0, 32'h0, 1'b1);
    @(negedge clk);
    chk("illegal_err_cnt", 64'(err_cnt), RC ? 64'd2 : 64'd1);
    @(posedge clk); #1;

    // Backpressure: four back-to-back requests, consumer stalled five cycles
    r0 = n_rsp;
    rsp_ready = 1'b0;
    ea = ref_enc(7'h33, 3'b000, 7'h20, 5'd5, 5'd6, 5'd7, 0);
    drive_req(7'h33, 3'b000, 7'h20, 5'd5, 5'd6, 5'd7, 0);
    wait_accept(1'b0);
    drive_req(7'h63, 3'b001, 7'd0, 5'd0, 5'd8, 5'd9, -3);
    wait_accept(1'b0);
    drive_req(7'h37, 3'b000, 7'd0, 5'd10, 5'd0, 5'd0, 12345);
    @(negedge clk);
    chk("bp_req_ready_low", 64'(req_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_req_ready_held", 64'(req_ready), 64'd0);
      chk("bp_rsp_valid_held", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_instr_stable", 64'(rsp_instr), 64'(ea.instr));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_accept(1'b0);
    drive_req(7'h6F, 3'b000, 7'd0, 5'd31, 5'd0, 5'd0, -200);
    wait_accept(1'b0);
    drain();
    chk("bp_rsp_count", 64'(n_rsp - r0), 64'd4);

    // Full rate: eight requests with consumer always ready
    rsp_ready = 1'b1;
    drive_req(7'h03, 3'b010, 7'd0, 5'd1, 5'd2, 5'd0, 16);
    wait_accept(1'b0);
    c0 = cyc;
    for (int i = 1; i < 8; i++) begin
      drive_req(7'h13, 3'b000, 7'd0, 5'(i), 5'(i), 5'd0, longint'(i));
      wait_accept(1'b0);
    end
    chk("full_rate_cycles", 64'(cyc - c0), 64'd7);
    drain();

    // Reset while two requests are in flight
    rsp_ready = 1'b0;
    drive_req(7'h13, 3'b000, 7'd0, 5'd3, 5'd4, 5'd0, 7);
    wait_accept(1'b0);
    drive_req(7'h7F, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 0);
    wait_accept(1'b0);
    req_valid = 1'b0;
    @(negedge clk);
    chk("inflight_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("postrst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale_rsp", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Randomized requests with random consumer stalls
    for (int i = 0; i < 300; i++) begin
      logic [6:0] opc;
      longint imm;
      int k;
      k = $urandom_range(0, 9);
      case (k)
        0: opc = 7'h33; 1: opc = 7'h13; 2: opc = 7'h03; 3: opc = 7'h67;
        4: opc = 7'h23; 5: opc = 7'h63; 6: opc = 7'h37; 7: opc = 7'h17;
        8: opc = 7'h6F; default: opc = 7'($urandom);
      endcase
      k = $urandom_range(0, 3);
      case (k)
        0: imm = longint'($urandom_range(0, 80)) - 40;
        1: begin
          case ($urandom_range(0, 9))
            0: imm = -2049;   1: imm = -2048;   2: imm = 2047;   3: imm = 2048;
            4: imm = 31;      5: imm = 32;      6: imm = -524288; 7: imm = -524289;
            8: imm = 524287;  default: imm = 524288;
          endcase
        end
        2: imm = longint'($urandom_range(0, 4095)) - 2048;
        default: imm = longint'({$urandom(), $urandom()});
      endcase
      drive_req(opc, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
                5'($urandom), imm);
      wait_accept(1'b1);
      if ($urandom_range(0, 4) == 0) begin
        req_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    drain();

    // Saturation of the error counter
    rsp_ready = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      drive_req(7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
      wait_accept(1'b0);
    end
    drain();
    @(negedge clk);
    chk("err_cnt_saturated", 64'(err_cnt), 64'hFFFF);
    @(posedge clk); #1;
    expect_one("illegal_sat", 7'h7F, 3'b000, 5'd0, 5'd0, 5'd0, 0, 32'h0, 1'b1);
    @(negedge clk);
    chk("err_cnt_stays_sat", 64'(err_cnt), 64'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_instr_enc.md
Name: riscv_instr_enc

Overview:
- Instruction encoder: assembles a 32-bit RV32I instruction word from opcode, funct, register and immediate fields.
- Exact inverse of the core's immediate decode convention.
- Serves the debug module's program-buffer builder and the self-test instruction generator. These drive an instruction into the IBUS-side path.
- Two-stage valid/ready pipeline, 1 instr/cycle throughput, immediate range checking and a saturating error counter.

Parameters:
IBUS_DATA_WIDTH, 32, encoded instruction width; only 32 supported.
DBUS_DATA_WIDTH, 64, width of req_imm.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request valid
req_ready  output  1  encoder accepts request this cycle
req_opcode  input  7  opcode field
req_funct3  input  3  funct3
req_funct7  input  7  funct7 (R-type, and OP_IMM shifts)
req_rd  input  5  destination register
req_rs1  input  5  source register 1
req_rs2  input  5  source register 2
req_imm  input  DBUS_DATA_WIDTH  signed immediate, decoder convention
rsp_valid  output  1  encoded word valid
rsp_ready  input  1  consumer accepts word
rsp_instr  output  IBUS_DATA_WIDTH  encoded instruction
rsp_err  output  1  request was illegal or out of range
err_cnt  output  16  saturating count of rsp_err responses delivered

Behaviour:
- Clock is clk. Reset rst is synchronous, active-high.
- Reset values: rsp_valid=0, rsp_instr=0, rsp_err=0, err_cnt=0, both stage valids=0. req_ready=0 while rst=1.
- Format from opcode:
  - OP 0110011 = R.
  - OP_IMM 0010011, LOAD 0000011, JALR 1100111 = I.
  - STORE 0100011 = S.
  - BRANCH 1100011 = B.
  - LUI 0110111, AUIPC 0010111 = U.
  - JAL 1101111 = J.
  - Any other opcode = illegal: rsp_instr=0, rsp_err=1, regardless of macro.
- Immediate convention (value carried in req_imm, sign-extended to DBUS width):
  - I/S: imm[11:0].
  - B: offset[12:1].
  - U: bits[31:12].
  - J: offset[20:1].
- Placement:
  - I: imm[11:0]→[31:20].
  - S: imm[11:5]→[31:25], imm[4:0]→[11:7].
  - B: v[11]→31, v[10]→7, v[9:4]→[30:25], v[3:0]→[11:8].
  - U: v[19:0]→[31:12].
  - J: v[19]→31, v[18:11]→[19:12], v[10]→20, v[9:0]→[30:21].
  - R: funct7→[31:25], rs2→[24:20]; req_imm ignored.
  - Fields not used by a format are zero.
- Shift special case: OP_IMM with funct3 001 or 101 places funct7→[31:25] and imm[4:0]→[24:20].
- Stage E1 (register at accept): captures fields, computes format, encoding, and error.
- Stage E2: output register driving rsp_*.
- Latency: accept at cycle N → rsp_valid at N+2 when unstalled.
- Handshakes:
  - E2 advances when !rsp_valid || rsp_ready.
  - E1 advances into E2 when E2 advances.
  - req_ready = !rst && (!e1_valid || e1_advances). Combinational from rsp_ready; no combinational path from req_valid to req_ready.
- Stall: all held registers stable while rsp_valid && !rsp_ready; back-to-back throughput 1/cycle. Order preserved, no drop, no duplicate.
- err_cnt increments on rsp_valid && rsp_ready && rsp_err; saturates at 0xFFFF.
- Reset mid-operation: all in-flight requests are discarded; no response emitted after rst deasserts.

Optional Feature:
- Macro: RISCV_INSTR_ENC_RANGE_CHECK_EN.
- Defined: rsp_err=1 (encoding still emitted, truncated) if any of the following hold:
  - I/S value not in [-2048, 2047].
  - B/U/J value not representable in 12/20/20 signed bits, i.e. upper req_imm bits are not all equal to the sign bit.
  - Shift shamt imm[DBUS-1:5] ≠ 0.
- Undefined: immediate silently truncated; rsp_err only for illegal opcode.

Test Plan:
- addi x1,x0,-1 (opc 0010011, f3 000, rd 1, rs1 0, imm -1) → rsp_instr 0xFFF00093, rsp_err 0, valid exactly 2 cycles after accept.
- sw x2,8(x3) (opc 0100011, f3 010, rs1 3, rs2 2, imm 8) → 0x0021A423. jal x1 imm 1024 (offset 2048) → 0x001000EF.
- addi x1,x0 imm 2048 → with macro: rsp_err 1, err_cnt 1 after handshake; without macro: 0x80000093, rsp_err 0, err_cnt 0.
- opcode 0x7F → rsp_instr 0, rsp_err 1 in both builds; err_cnt preloaded to 0xFFFF via repeated errors stays 0xFFFF.
- 4 back-to-back requests, rsp_ready low 5 cycles → req_ready drops after 2 accepted, then 4 responses in order, none lost; full rate with rsp_ready=1.
- rst pulsed 1 cycle while 2 requests in flight → rsp_valid 0 next cycle, req_ready 1 after rst low, no stale response.
